// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state encoding and sizing for the 4:1 arbitrated mux
package mux_arb_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    localparam int NUM_REQ = 4;
    localparam int SEL_W = 2;
    localparam logic [SEL_W-1:0] RESET_LAST = 2'd3;
endpackage

// File: rtl/mux_4x1.sv
// mux_4x1: plain 4:1 data selector driven by the registered grant index
module mux_4x1
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i,
    input  logic [SEL_W-1:0]   s,
    output logic               F
);
    assign F = i[s];
endmodule

// File: rtl/mux_arbiter_4x1.sv
// mux_arbiter_4x1: round-robin 4-requester arbiter feeding a 4:1 mux.
// Define MUX_ARB_TIMEOUT_EN to cap a grant at TIMEOUT consecutive cycles.
module mux_arbiter_4x1
    import mux_arb_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] i,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       valid,
    output logic       F
);
    state_t           state, state_n;
    logic [SEL_W-1:0] last, pick;
    logic             timeout_hit, mux_f;
    // Scan from lowest priority (last itself) up to last+1 so the nearest requester wins
    always_comb begin
        pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pick = req[2'(last + 2'(k))] ? 2'(last + 2'(k)) : pick;
        end
        state_n = (state == IDLE) ? (|req ? GRANT : IDLE)
                                  : ((req[s] && !timeout_hit) ? GRANT : IDLE);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            last  <= RESET_LAST;
        end else begin
            state <= state_n;
            if (state == IDLE && |req) begin
                s    <= pick;
                last <= pick;
            end
        end
    end
`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] hold;
    // hold is 1 on the first granted cycle, so exit happens after exactly TIMEOUT cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hold <= '0;
        else       hold <= (state == GRANT) ? hold + 1'b1 : CNT_W'(1);
    end
    assign timeout_hit = (hold == CNT_W'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif
    assign valid = (state == GRANT);
    assign gnt   = {3'b000, valid} << s;
    mux_4x1 u_mux (.i(i), .s(s), .F(mux_f));
    assign F = mux_f & valid;
endmodule
